// File: rtl/rep_str_seq.sv
// ============================================================================
// rep_str_seq : execute-stage sequencer for x86 string instructions with
//               optional REP/REPE/REPNE prefix (MOVS, CMPS, STOS, LODS, SCAS).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rep_str_seq #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             str_start,
  input  logic [1:0]       str_rep,
  input  logic [2:0]       str_op,
  input  logic [CNT_W-1:0] ecx_in,
  input  logic             zf_in,
  input  logic             mem_ack,
  input  logic             flush,
  output logic             busy,
  output logic [3:0]       alu2_op,
  output logic             sr2_sel,
  output logic             ptr_wr_en,
  output logic             mem_rd_req,
  output logic             mem_wr_req,
  output logic             mem_addr_sel,
  output logic             cmp_en,
  output logic             acc_wr_en,
  output logic [CNT_W-1:0] ecx_out,
  output logic             ecx_wr_en,
  output logic             str_done
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CHK0    = 4'd1,
    S_RD_SRC  = 4'd2,
    S_RD_DST  = 4'd3,
    S_WR_DST  = 4'd4,
    S_CMP     = 4'd5,
    S_UPD_SRC = 4'd6,
    S_UPD_DST = 4'd7,
    S_CNT     = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  localparam logic [2:0] OP_MOVS = 3'd0;
  localparam logic [2:0] OP_CMPS = 3'd1;
  localparam logic [2:0] OP_STOS = 3'd2;
  localparam logic [2:0] OP_LODS = 3'd3;
  localparam logic [2:0] OP_SCAS = 3'd4;

  localparam logic [1:0] REP_E  = 2'b01;
  localparam logic [1:0] REP_NE = 2'b10;

  localparam logic [3:0] ALU2_STEP = 4'b0101;
  localparam logic [3:0] ALU2_ZERO = 4'b0011;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       rep_q, rep_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             zf_q, zf_d;

  logic             is_rep;
  logic             op_rsvd;
  logic             is_cmp_op;
  logic             zf_stop;
  logic [CNT_W-1:0] cnt_dec;
  state_t           first_phase;
  state_t           iter_end;

  assign is_rep    = (rep_q == REP_E) || (rep_q == REP_NE);
  assign op_rsvd   = (op_q > OP_SCAS);
  assign is_cmp_op = (op_q == OP_CMPS) || (op_q == OP_SCAS);
  assign zf_stop   = is_cmp_op &&
                     (((rep_q == REP_E) && !zf_q) || ((rep_q == REP_NE) && zf_q));
  assign cnt_dec   = count_q - CNT_W'(1);

  // A non-repeated instruction retires straight from its last pointer update.
  assign iter_end  = is_rep ? S_CNT : S_DONE;

  always_comb begin
    first_phase = S_RD_SRC;
    case (op_q)
      OP_STOS: first_phase = S_WR_DST;
      OP_SCAS: first_phase = S_RD_DST;
      default: first_phase = S_RD_SRC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      rep_q   <= 2'd0;
      count_q <= '0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rep_q   <= rep_d;
      count_q <= count_d;
      zf_q    <= zf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rep_d        = rep_q;
    count_d      = count_q;
    zf_d         = zf_q;
    alu2_op      = ALU2_ZERO;
    sr2_sel      = 1'b0;
    ptr_wr_en    = 1'b0;
    mem_rd_req   = 1'b0;
    mem_wr_req   = 1'b0;
    mem_addr_sel = 1'b0;
    cmp_en       = 1'b0;
    acc_wr_en    = 1'b0;
    ecx_out      = '0;
    ecx_wr_en    = 1'b0;
    str_done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (str_start) begin
          op_d    = str_op;
          rep_d   = str_rep;
          count_d = ecx_in;
          state_d = S_CHK0;
        end
      end
      S_CHK0: begin
        if ((is_rep && (count_q == '0)) || op_rsvd) state_d = S_DONE;
        else                                        state_d = first_phase;
      end
      S_RD_SRC: begin
        mem_rd_req = 1'b1;
        if (mem_ack) begin
          acc_wr_en = (op_q == OP_LODS);
          case (op_q)
            OP_MOVS: state_d = S_WR_DST;
            OP_CMPS: state_d = S_RD_DST;
            default: state_d = S_UPD_SRC;
          endcase
        end
      end
      S_RD_DST: begin
        mem_rd_req   = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ack) state_d = S_CMP;
      end
      S_WR_DST: begin
        mem_wr_req   = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ack) state_d = (op_q == OP_MOVS) ? S_UPD_SRC : S_UPD_DST;
      end
      S_CMP: begin
        cmp_en  = 1'b1;
        zf_d    = zf_in;
        state_d = (op_q == OP_CMPS) ? S_UPD_SRC : S_UPD_DST;
      end
      S_UPD_SRC: begin
        alu2_op   = ALU2_STEP;
        ptr_wr_en = 1'b1;
        state_d   = (op_q == OP_LODS) ? iter_end : S_UPD_DST;
      end
      S_UPD_DST: begin
        alu2_op   = ALU2_STEP;
        sr2_sel   = 1'b1;
        ptr_wr_en = 1'b1;
        state_d   = iter_end;
      end
      S_CNT: begin
        if (!is_rep) begin
          state_d = S_DONE;
        end else begin
          ecx_out   = cnt_dec;
          ecx_wr_en = 1'b1;
          count_d   = cnt_dec;
          if ((cnt_dec == '0) || zf_stop) state_d = S_DONE;
          else                            state_d = first_phase;
        end
      end
      S_DONE: begin
        str_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort: all side effects of the current cycle are suppressed.
    if (flush) begin
      state_d    = S_IDLE;
      ptr_wr_en  = 1'b0;
      mem_rd_req = 1'b0;
      mem_wr_req = 1'b0;
      cmp_en     = 1'b0;
      acc_wr_en  = 1'b0;
      ecx_wr_en  = 1'b0;
      str_done   = 1'b0;
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rep_str_seq.sv
// ============================================================================
// tb_rep_str_seq : directed self-checking bench for rep_str_seq.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_rep_str_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        str_start;
  logic [1:0]  str_rep;
  logic [2:0]  str_op;
  logic [31:0] ecx_in;
  logic        zf_in;
  logic        mem_ack;
  logic        flush;
  logic        busy;
  logic [3:0]  alu2_op;
  logic        sr2_sel;
  logic        ptr_wr_en;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic        mem_addr_sel;
  logic        cmp_en;
  logic        acc_wr_en;
  logic [31:0] ecx_out;
  logic        ecx_wr_en;
  logic        str_done;

  always #5 clk = ~clk;

  rep_str_seq #(.CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .str_start    (str_start),
    .str_rep      (str_rep),
    .str_op       (str_op),
    .ecx_in       (ecx_in),
    .zf_in        (zf_in),
    .mem_ack      (mem_ack),
    .flush        (flush),
    .busy         (busy),
    .alu2_op      (alu2_op),
    .sr2_sel      (sr2_sel),
    .ptr_wr_en    (ptr_wr_en),
    .mem_rd_req   (mem_rd_req),
    .mem_wr_req   (mem_wr_req),
    .mem_addr_sel (mem_addr_sel),
    .cmp_en       (cmp_en),
    .acc_wr_en    (acc_wr_en),
    .ecx_out      (ecx_out),
    .ecx_wr_en    (ecx_wr_en),
    .str_done     (str_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Responder controls
  int          ack_delay = 1;
  int          wait_cnt  = 0;
  logic [15:0] zf_seq    = 16'h0;
  int          zf_idx    = 0;

  // Monitor counters
  int          rd_acks, wr_acks, wr_dst, rd_req_cyc, wr_req_cyc;
  int          ptr_wr, ptr_step, ecx_wr, done_cnt, acc_wr;
  logic [31:0] last_ecx;
  logic [31:0] ecx_hist [0:7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rd_acks = 0; wr_acks = 0; wr_dst = 0; rd_req_cyc = 0; wr_req_cyc = 0;
    ptr_wr = 0; ptr_step = 0; ecx_wr = 0; done_cnt = 0; acc_wr = 0;
    last_ecx = 32'hdead_beef; zf_idx = 0;
    for (int i = 0; i < 8; i++) ecx_hist[i] = 32'hffff_ffff;
  endtask

  // Memory/compare responder: ack after ack_delay request cycles.
  initial begin
    mem_ack = 1'b0;
    zf_in   = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd_req || mem_wr_req) begin
        if (wait_cnt >= ack_delay - 1) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
        end else begin
          mem_ack  = 1'b0;
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
      if (cmp_en) begin
        zf_in  = zf_seq[zf_idx[3:0]];
        zf_idx = zf_idx + 1;
      end
    end
  end

  // Monitor: sampled mid-cycle after the responder has settled.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mem_rd_req && mem_ack) rd_acks++;
      if (mem_wr_req && mem_ack) begin
        wr_acks++;
        if (mem_addr_sel) wr_dst++;
      end
      if (mem_rd_req) rd_req_cyc++;
      if (mem_wr_req) wr_req_cyc++;
      if (ptr_wr_en) begin
        ptr_wr++;
        if (alu2_op == 4'b0101) ptr_step++;
      end
      if (ecx_wr_en) begin
        if (ecx_wr < 8) ecx_hist[ecx_wr] = ecx_out;
        ecx_wr++;
        last_ecx = ecx_out;
      end
      if (str_done) done_cnt++;
      if (acc_wr_en) acc_wr++;
    end
  end

  // Pulse str_start and run until str_done; returns cycles from start to done.
  task automatic run(input logic [2:0] op, input logic [1:0] rep, input logic [31:0] ecx,
                     output int cyc);
    bit seen;
    clear_mon();
    str_op    = op;
    str_rep   = rep;
    ecx_in    = ecx;
    str_start = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      str_start = 1'b0;
      #2;
      cyc++;
      if (str_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_within_budget", 32'(seen), 32'd1);
  endtask

  initial begin
    int cyc;
    bit found;
    rst = 1'b1; str_start = 1'b0; str_rep = 2'b00; str_op = 3'd0;
    ecx_in = 32'd0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy",    32'(busy),     32'd0);
    chk("rst_alu2_op", 32'(alu2_op),  32'h3);
    chk("rst_ecx_out", ecx_out,       32'd0);
    chk("rst_strobes", {22'd0, sr2_sel, ptr_wr_en, mem_rd_req, mem_wr_req, mem_addr_sel,
                        cmp_en, acc_wr_en, ecx_wr_en, str_done, 1'b0}, 32'd0);
    rst = 1'b0;

    // MOVS, no prefix
    ack_delay = 1;
    run(3'd0, 2'b00, 32'd5, cyc);
    chk("movs_cycles",  32'(cyc),      32'd6);
    chk("movs_reads",   32'(rd_acks),  32'd1);
    chk("movs_writes",  32'(wr_acks),  32'd1);
    chk("movs_ptr_wr",  32'(ptr_wr),   32'd2);
    chk("movs_ptr_op",  32'(ptr_step), 32'd2);
    chk("movs_ecx_wr",  32'(ecx_wr),   32'd0);
    @(negedge clk); #2;
    chk("movs_idle",    32'(busy),     32'd0);

    // REP STOS, ECX=3
    run(3'd2, 2'b01, 32'd3, cyc);
    chk("stos_cycles",  32'(cyc),      32'd11);
    chk("stos_writes",  32'(wr_acks),  32'd3);
    chk("stos_wr_edi",  32'(wr_dst),   32'd3);
    chk("stos_reads",   32'(rd_acks),  32'd0);
    chk("stos_ecx0",    ecx_hist[0],   32'd2);
    chk("stos_ecx1",    ecx_hist[1],   32'd1);
    chk("stos_ecx2",    ecx_hist[2],   32'd0);
    chk("stos_ecx_wr",  32'(ecx_wr),   32'd3);
    @(negedge clk); #2;

    // REP MOVS, ECX=0
    run(3'd0, 2'b01, 32'd0, cyc);
    chk("movs0_cycles", 32'(cyc),                   32'd2);
    chk("movs0_reqs",   32'(rd_req_cyc + wr_req_cyc), 32'd0);
    chk("movs0_ptr_wr", 32'(ptr_wr),                32'd0);
    chk("movs0_ecx_wr", 32'(ecx_wr),                32'd0);
    @(negedge clk); #2;

    // REPE CMPS, ECX=10, ZF 1,1,0
    zf_seq = 16'b0000_0000_0000_0011;
    run(3'd1, 2'b01, 32'd10, cyc);
    chk("cmps_cycles",  32'(cyc),     32'd20);
    chk("cmps_reads",   32'(rd_acks), 32'd6);
    chk("cmps_ptr_wr",  32'(ptr_wr),  32'd6);
    chk("cmps_ecx_wr",  32'(ecx_wr),  32'd3);
    chk("cmps_ecx_end", last_ecx,     32'd7);
    @(negedge clk); #2;

    // REPNE SCAS, ECX=4, ZF=0, 3-cycle memory
    zf_seq    = 16'h0000;
    ack_delay = 3;
    run(3'd4, 2'b10, 32'd4, cyc);
    chk("scas_cycles",  32'(cyc),        32'd26);
    chk("scas_rd_hold", 32'(rd_req_cyc), 32'd12);
    chk("scas_reads",   32'(rd_acks),    32'd4);
    chk("scas_ecx_wr",  32'(ecx_wr),     32'd4);
    chk("scas_ecx_end", last_ecx,        32'd0);
    @(negedge clk); #2;

    // LODS no prefix, then reserved op with REP
    ack_delay = 1;
    run(3'd3, 2'b00, 32'd9, cyc);
    chk("lods_cycles",  32'(cyc),    32'd4);
    chk("lods_acc_wr",  32'(acc_wr), 32'd1);
    @(negedge clk); #2;
    run(3'd5, 2'b01, 32'd3, cyc);
    chk("rsvd_cycles",  32'(cyc),                     32'd2);
    chk("rsvd_reqs",    32'(rd_req_cyc + wr_req_cyc), 32'd0);
    @(negedge clk); #2;

    // REP LODS, ECX=8, flush during second RD_SRC with a coincident str_start
    clear_mon();
    str_op = 3'd3; str_rep = 2'b01; ecx_in = 32'd8; str_start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      str_start = 1'b0;
      #2;
      if (mem_rd_req && rd_acks == 2) begin
        found = 1'b1;
        break;
      end
    end
    chk("flush_reached_rd2", 32'(found), 32'd1);
    flush = 1'b1; str_start = 1'b1;
    #1;
    chk("flush_req_drop", 32'(mem_rd_req), 32'd0);
    chk("flush_acc_drop", 32'(acc_wr_en),  32'd0);
    @(negedge clk); #2;
    chk("flush_idle",     32'(busy),       32'd0);
    flush = 1'b0; str_start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    chk("flush_stay_idle", 32'(busy),     32'd0);
    chk("flush_no_done",   32'(done_cnt), 32'd0);
    chk("flush_ecx_wr",    32'(ecx_wr),   32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
